// File: rtl/tcp_misc_pkg.sv
// Shared entry type and timestamp staleness helper for sched_flag_table.
// Define SCHED_FLAG_TS_WRAP_EN to compare timestamps as wrapping serial numbers.
package tcp_misc_pkg;

    localparam int SCHED_TS_W = 8;

    typedef struct packed {
        logic                  flag;
        logic [SCHED_TS_W-1:0] ts;
        logic                  inflight;
    } sched_entry_t;

    // A clear is stale when the clearer saw an older timestamp than the table holds.
    function automatic logic sched_clear_stale(input logic [SCHED_TS_W-1:0] stored_ts,
                                               input logic [SCHED_TS_W-1:0] clear_ts);
`ifdef SCHED_FLAG_TS_WRAP_EN
        logic [SCHED_TS_W-1:0] diff;
        diff = stored_ts - clear_ts;
        return (diff != '0) && !diff[SCHED_TS_W-1];
`else
        return clear_ts < stored_ts;
`endif
    endfunction

endpackage

// File: rtl/sched_flag_table_if.sv
// Command, offer and status signals of sched_flag_table.
// The slave modport is the table; the master modport is the producer/consumer side.
interface sched_flag_table_if #(
    parameter int NUM_FLOWS = 16,
    parameter int FLOW_ID_W = $clog2(NUM_FLOWS),
    parameter int TS_W      = tcp_misc_pkg::SCHED_TS_W
);
    logic                 set_val;
    logic [FLOW_ID_W-1:0] set_flowid;
    logic                 set_rdy;
    logic                 clear_val;
    logic [FLOW_ID_W-1:0] clear_flowid;
    logic [TS_W-1:0]      clear_ts;
    logic                 clear_rdy;
    logic                 sched_val;
    logic [FLOW_ID_W-1:0] sched_flowid;
    logic [TS_W-1:0]      sched_ts;
    logic                 sched_rdy;
    logic [NUM_FLOWS-1:0] flag_vec;

    modport master (
        output set_val, set_flowid, clear_val, clear_flowid, clear_ts, sched_rdy,
        input  set_rdy, clear_rdy, sched_val, sched_flowid, sched_ts, flag_vec
    );

    modport slave (
        input  set_val, set_flowid, clear_val, clear_flowid, clear_ts, sched_rdy,
        output set_rdy, clear_rdy, sched_val, sched_flowid, sched_ts, flag_vec
    );
endinterface

// File: rtl/sched_flag_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after the pointer,
// wrapping from N-1 back to 0.
module sched_flag_rr_pick #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] elig_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);
    int j;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!valid_o && elig_i[j]) begin
                valid_o = 1'b1;
                idx_o   = W'(j);
            end
        end
    end
endmodule

// File: rtl/sched_flag_table.sv
// Per-flow flag/timestamp table with a round-robin offer port.
// Build option: SCHED_FLAG_TS_WRAP_EN selects wrapping timestamp comparison for clears.
module sched_flag_table
    import tcp_misc_pkg::*;
#(
    parameter int NUM_FLOWS = 16,
    parameter int FLOW_ID_W = $clog2(NUM_FLOWS),
    parameter int TS_W      = SCHED_TS_W
) (
    input  logic              clk,
    input  logic              rst,
    sched_flag_table_if.slave bus
);
    sched_entry_t         tbl_q [NUM_FLOWS];
    sched_entry_t         tbl_d [NUM_FLOWS];
    logic [FLOW_ID_W-1:0] ptr_q, ptr_d;
    logic [FLOW_ID_W-1:0] sched_flowid_q, sched_flowid_d;
    logic                 sched_val_q, sched_val_d;
    logic                 rdy_q;
    logic                 handshake;
    logic                 pick_valid;
    logic [FLOW_ID_W-1:0] pick_idx;
    logic [NUM_FLOWS-1:0] elig;
    logic [NUM_FLOWS-1:0] flag_vec;
    logic [TS_W-1:0]      sched_ts;

    assign handshake = sched_val_q && bus.sched_rdy;

    // Order matters: accept, then clear (judged on pre-set ts), then set.
    always_comb begin : table_next
        tbl_d = tbl_q;
        if (handshake) begin
            tbl_d[sched_flowid_q].inflight = 1'b1;
        end
        if (bus.clear_val) begin
            if (!sched_clear_stale(tbl_q[bus.clear_flowid].ts, bus.clear_ts)) begin
                tbl_d[bus.clear_flowid].flag = 1'b0;
            end
            tbl_d[bus.clear_flowid].inflight = 1'b0;
        end
        if (bus.set_val) begin
            tbl_d[bus.set_flowid].flag = 1'b1;
            tbl_d[bus.set_flowid].ts   = tbl_q[bus.set_flowid].ts + SCHED_TS_W'(1);
        end
    end

    // Selection looks at next-state so offers track the table without an extra cycle.
    always_comb begin : elig_calc
        elig = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            elig[i] = tbl_d[i].flag && !tbl_d[i].inflight &&
                      !(sched_val_q && (sched_flowid_q == FLOW_ID_W'(i)));
        end
    end

    always_comb begin : ptr_next
        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (sched_flowid_q == FLOW_ID_W'(NUM_FLOWS - 1)) ? '0
                                                                  : sched_flowid_q + FLOW_ID_W'(1);
        end
    end

    sched_flag_rr_pick #(
        .N (NUM_FLOWS),
        .W (FLOW_ID_W)
    ) u_pick (
        .elig_i  (elig),
        .ptr_i   (ptr_d),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin : offer_next
        sched_val_d    = sched_val_q;
        sched_flowid_d = sched_flowid_q;
        if (!sched_val_q || handshake) begin
            sched_val_d = pick_valid;
            if (pick_valid) begin
                sched_flowid_d = pick_idx;
            end
        end else if (!tbl_d[sched_flowid_q].flag) begin
            sched_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                tbl_q[i] <= '0;
            end
            ptr_q          <= '0;
            sched_val_q    <= 1'b0;
            sched_flowid_q <= '0;
            rdy_q          <= 1'b0;
        end else begin
            tbl_q          <= tbl_d;
            ptr_q          <= ptr_d;
            sched_val_q    <= sched_val_d;
            sched_flowid_q <= sched_flowid_d;
            rdy_q          <= 1'b1;
        end
    end

    always_comb begin : flag_out
        flag_vec = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            flag_vec[i] = tbl_q[i].flag;
        end
    end

    assign sched_ts         = tbl_q[sched_flowid_q].ts;
    assign bus.set_rdy      = rdy_q;
    assign bus.clear_rdy    = rdy_q;
    assign bus.sched_val    = sched_val_q;
    assign bus.sched_flowid = sched_flowid_q;
    assign bus.sched_ts     = sched_ts;
    assign bus.flag_vec     = flag_vec;
endmodule
